// File: rtl/status_display_ctrl_if.sv
// Status-in / HEX-out bundle between the pipeline status outputs, the display sequencer and the board pins.
interface status_display_ctrl_if;
  logic       stall;
  logic       exception;
  logic       PC_unvalid;
  logic       clear;
  logic [6:0] HEX2;
  logic [6:0] HEX1;
  logic [6:0] HEX0;

  modport master (output stall, exception, PC_unvalid, clear, input HEX2, HEX1, HEX0);
  modport slave  (input stall, exception, PC_unvalid, clear, output HEX2, HEX1, HEX0);
endinterface

// File: rtl/status_display_ctrl.sv
// 3-digit 7-seg status sequencer: counts stall/exception/PC_unvalid rising edges and rotates the display
// through each flagged event. Optional letter blink via `define STATUS_BLINK_EN.

// Per-event edge counter with sticky flag; clear wins, but a same-cycle edge still counts once.
module status_event_cnt #(
  parameter int CNT_MAX = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev,
  input  logic       clr,
  output logic [6:0] cnt,
  output logic       flag
);
  logic       prev_q;
  logic [6:0] cnt_q, cnt_d;
  logic       flag_q, flag_d;
  logic       ev_edge;

  assign ev_edge = ev & ~prev_q;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clr) begin
      cnt_d  = ev_edge ? 7'd1 : 7'd0;
      flag_d = ev_edge;
    end else if (ev_edge) begin
      cnt_d  = (cnt_q == 7'(CNT_MAX)) ? 7'(CNT_MAX) : cnt_q + 7'd1;
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      prev_q <= ev;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign cnt  = cnt_q;
  assign flag = flag_q;
endmodule

module status_display_ctrl #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_MAX      = 99
) (
  input  logic                 clk,
  input  logic                 rst,
  status_display_ctrl_if.slave bus
);
  localparam int NUM_EV = 3;
  localparam int TW     = $clog2(DWELL_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SHOW_S, SHOW_E, SHOW_U} state_e;

  logic [NUM_EV-1:0]      ev;
  logic [NUM_EV-1:0]      flag;
  logic [NUM_EV-1:0][6:0] cnt;

  // event index order is S=0, E=1, U=2, which is also the rotation order
  assign ev = {bus.PC_unvalid, bus.exception, bus.stall};

  for (genvar i = 0; i < NUM_EV; i++) begin : g_ev
    status_event_cnt #(.CNT_MAX(CNT_MAX)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .ev   (ev[i]),
      .clr  (bus.clear),
      .cnt  (cnt[i]),
      .flag (flag[i])
    );
  end

  // Nearest flagged index after 'from' in cyclic order; 'from' itself is the last resort.
  function automatic logic [1:0] next_flagged(input logic [2:0] f, input logic [1:0] from);
    logic [1:0] idx;
    next_flagged = from;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(from) + k) % 3);
      if (f[idx]) next_flagged = idx;
    end
  endfunction

  function automatic state_e show_of(input logic [1:0] idx);
    case (idx)
      2'd0:    show_of = SHOW_S;
      2'd1:    show_of = SHOW_E;
      default: show_of = SHOW_U;
    endcase
  endfunction

  function automatic logic [6:0] seg(input logic [6:0] v);
    case (v)
      7'd0:    seg = 7'b1000000;
      7'd1:    seg = 7'b1111001;
      7'd2:    seg = 7'b0100100;
      7'd3:    seg = 7'b0110000;
      7'd4:    seg = 7'b0011001;
      7'd5:    seg = 7'b0010010;
      7'd6:    seg = 7'b0000010;
      7'd7:    seg = 7'b1111000;
      7'd8:    seg = 7'b0000000;
      7'd9:    seg = 7'b0010000;
      default: seg = BLANK;
    endcase
  endfunction

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [1:0]    cur;

  always_comb begin
    case (state_q)
      SHOW_E:  cur = 2'd1;
      SHOW_U:  cur = 2'd2;
      default: cur = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (|flag) state_q <= show_of(next_flagged(flag, 2'd2));
        end
        default: begin
          // a clear that drops the shown event preempts the dwell
          if (!flag[cur]) begin
            state_q <= IDLE;
            timer_q <= '0;
          end else if (timer_q == LAST) begin
            state_q <= show_of(next_flagged(flag, cur));
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
      endcase
    end
  end

  logic [6:0] sel_cnt, tens, ones;
  logic [6:0] hex2_q, hex2_d, hex1_q, hex1_d, hex0_q, hex0_d;

  always_comb begin
    sel_cnt = cnt[cur];
    tens    = sel_cnt / 7'd10;
    ones    = sel_cnt % 7'd10;
    hex2_d  = BLANK;
    hex1_d  = BLANK;
    hex0_d  = BLANK;
    if (state_q != IDLE) begin
      case (cur)
        2'd0:    hex2_d = 7'b0010010;
        2'd1:    hex2_d = 7'b0000110;
        default: hex2_d = 7'b1000001;
      endcase
`ifdef STATUS_BLINK_EN
      if (timer_q >= TW'(DWELL_CYCLES / 2)) hex2_d = BLANK;
`endif
      hex1_d = (tens == 7'd0) ? BLANK : seg(tens);
      hex0_d = seg(ones);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hex2_q <= BLANK;
      hex1_q <= BLANK;
      hex0_q <= BLANK;
    end else begin
      hex2_q <= hex2_d;
      hex1_q <= hex1_d;
      hex0_q <= hex0_d;
    end
  end

  assign bus.HEX2 = hex2_q;
  assign bus.HEX1 = hex1_q;
  assign bus.HEX0 = hex0_q;
endmodule

// File: tb/tb_status_display_ctrl.sv
// Scoreboard bench for status_display_ctrl: event-level reference model, randomized status traffic.
module tb_status_display_ctrl;
  localparam int DW = 4;
  localparam int CM = 99;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  status_display_ctrl_if sif();

  status_display_ctrl #(.DWELL_CYCLES(DW), .CNT_MAX(CM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [20:0] exp_q[$];

  logic [6:0] seg_t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [6:0] let_t [3]  = '{7'b0010010, 7'b0000110, 7'b1000001};

  // reference state: which event is on display (-1 none), how long it has dwelt
  int m_cnt[3], m_flag[3], m_prev[3];
  int m_cur = -1;
  int m_t   = 0;

  function automatic logic [20:0] model_disp();
    logic [6:0] l, h1, h0;
    if (m_cur < 0) return {3{7'h7F}};
    l = let_t[m_cur];
`ifdef STATUS_BLINK_EN
    if (m_t >= DW / 2) l = 7'h7F;
`endif
    h1 = (m_cnt[m_cur] / 10 == 0) ? 7'h7F : seg_t[m_cnt[m_cur] / 10];
    h0 = seg_t[m_cnt[m_cur] % 10];
    return {l, h1, h0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_flag[i] = 0; m_prev[i] = 0;
    end
    m_cur = -1;
    m_t   = 0;
  endtask

  task automatic model_step();
    int inp[3];
    int nxt;
    logic [20:0] d;
    d = model_disp();
    inp[0] = int'(sif.stall);
    inp[1] = int'(sif.exception);
    inp[2] = int'(sif.PC_unvalid);
    if (m_cur < 0) begin
      nxt = 0;
      while (nxt < 3 && m_flag[nxt] == 0) nxt++;
      if (nxt < 3) m_cur = nxt;
      m_t = 0;
    end else if (m_flag[m_cur] == 0) begin
      m_cur = -1;
      m_t   = 0;
    end else if (m_t == DW - 1) begin
      nxt = (m_cur + 1) % 3;
      while (m_flag[nxt] == 0) nxt = (nxt + 1) % 3;
      m_cur = nxt;
      m_t   = 0;
    end else begin
      m_t++;
    end
    for (int i = 0; i < 3; i++) begin
      int e;
      e = (inp[i] != 0 && m_prev[i] == 0) ? 1 : 0;
      if (sif.clear) begin
        m_cnt[i]  = e;
        m_flag[i] = e;
      end else if (e != 0) begin
        m_cnt[i]  = (m_cnt[i] + 1 > CM) ? CM : m_cnt[i] + 1;
        m_flag[i] = 1;
      end
      m_prev[i] = inp[i];
    end
    exp_q.push_back(d);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
        exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // monitor: one display word per cycle, compared away from the active edge
  initial begin
    logic [20:0] e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {sif.HEX2, sif.HEX1, sif.HEX0};
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL display t=%0t got=%h_%h_%h exp=%h_%h_%h", $time,
                   g[20:14], g[13:7], g[6:0], e[20:14], e[13:7], e[6:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h_%h_%h exp=%h_%h_%h", name,
               got[20:14], got[13:7], got[6:0], exp[20:14], exp[13:7], exp[6:0]);
    end
  endtask

  task automatic drive(input logic s, input logic e, input logic u, input logic c);
    @(negedge clk);
    sif.stall = s; sif.exception = e; sif.PC_unvalid = u; sif.clear = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  initial begin
    sif.stall = 0; sif.exception = 0; sif.PC_unvalid = 0; sif.clear = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_blank", {sif.HEX2, sif.HEX1, sif.HEX0}, {3{7'h7F}});
    idle(3);

    // single stall pulse: display valid two edges after the sampling edge
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("first_pulse", {sif.HEX2, sif.HEX1, sif.HEX0}, {7'b0010010, 7'h7F, 7'b1111001});
    idle(5);

    // held level counts once, then a second pulse
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 0);
    idle(4);
    drive(1, 0, 0, 0);
    idle(6);

    // saturation on exception only
    drive(0, 0, 0, 1);
    for (int i = 0; i < 120; i++) begin
      drive(0, 1, 0, 0);
      drive(0, 0, 0, 0);
    end
    idle(3);
    check("saturate_99", {sif.HEX2, sif.HEX1, sif.HEX0}, {7'b0000110, 7'b0010000, 7'b0010000});

    // S and U rotate, E absent
    drive(0, 0, 0, 1);
    drive(1, 0, 1, 0);
    drive(0, 0, 0, 0);
    idle(20);

    // clear coinciding with a stall edge while E is flagged, then clear alone
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    idle(6);
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 0);
    idle(8);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    idle(4);
    check("clear_blank", {sif.HEX2, sif.HEX1, sif.HEX0}, {3{7'h7F}});

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom_range(63) == 0);

    // asynchronous reset in the middle of activity
    drive(1, 1, 1, 0);
    idle(3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("midrun_reset", {sif.HEX2, sif.HEX1, sif.HEX0}, {3{7'h7F}});
    @(negedge clk);
    #2 rst = 1'b1;
    idle(10);
    check("post_reset_blank", {sif.HEX2, sif.HEX1, sif.HEX0}, {3{7'h7F}});

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
